alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Multi-cycle issue/execute controller that drives the 18-bit ALU (op 00=ADD, 01=AND, 10=OR, 11=XOR).
//  Accepts one instruction word per handshake and reads both operands from the external register file.
//  Drives alu_a/alu_b/alu_op, captures alu_result, then writes it back to the register file.
//  Sits between instruction fetch (upstream) and the ALU plus register file (downstream).
// PARAMETERS
//  DATA_W  18  datapath and instruction width
//  REG_AW  4   register address width (16 registers)
//  IMM_W   6   immediate field width, sign-extended to DATA_W
// PORTS
//  clk          in   1       single clock, rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  instr_valid  in   1       upstream has an instruction
//  instr_ready  out  1       controller can accept (high only in IDLE)
//  instr        in   DATA_W  instruction word
//  rf_raddr1    out  REG_AW  read port 1 address (synchronous-read RF, 1-cycle latency)
//  rf_raddr2    out  REG_AW  read port 2 address
//  rf_rdata1    in   DATA_W  read data 1
//  rf_rdata2    in   DATA_W  read data 2
//  rf_we        out  1       write enable, one cycle per legal instruction
//  rf_waddr     out  REG_AW  write address
//  rf_wdata     out  DATA_W  write data
//  alu_a        out  DATA_W  ALU operand A
//  alu_b        out  DATA_W  ALU operand B
//  alu_op       out  2       ALU operation select
//  alu_result   in   DATA_W  ALU result (combinational from alu_a/alu_b/alu_op)
//  done         out  1       1-cycle pulse coincident with rf_we
//  err          out  1       1-cycle pulse on illegal opcode
// BEHAVIOUR
//  - Format: op[17:14], dst[13:10], src1[9:6]; R-type src2[5:2] ([1:0] ignored); I-type imm[5:0].
//  - Opcodes: 0000 ADD, 0001 ADDI, 0010 AND, 0011 ANDI, 0100 OR, 0101 ORI, 0110 XOR, 0111 XORI.
//    op[3] is 0 for all legal opcodes; alu_op = op[2:1]; op[0]=1 selects the I-type variant.
//  - Opcodes 1xxx are illegal.
//  - FSM: IDLE -> READ -> EXEC -> WB -> IDLE; illegal path: IDLE -> ERR -> IDLE.
//  - IDLE: instr_ready=1. On instr_valid&instr_ready, latch instr and decoded fields.
//    Next state: READ if the opcode is legal, else ERR.
//  - READ: rf_raddr1=src1 and rf_raddr2=src2 come from the latched fields; rf_rdata is valid in EXEC.
//  - EXEC: alu_a=rf_rdata1, alu_b = I-type ? sext(imm) : rf_rdata2, alu_op=op[2:1].
//    alu_result is registered into result_q at the end of EXEC.
//  - WB: rf_we=1, rf_waddr=dst, rf_wdata=result_q, done=1.
//  - Latency: acceptance edge to rf_we is 3 cycles. Throughput is 1 instruction per 4 cycles.
//  - ERR: err=1 for one cycle; no RF write; instr_ready=0.
//  - Arithmetic: ADD wraps modulo 2^18 with no carry out. The immediate sign-extends from bit 5.
//  - Outside its active state, each output holds 0: rf_we, done, err, alu_*, rf_*addr, rf_wdata.
//  - dst/src may alias (e.g. ADD r1,r1,r1); operands are read before the write, so this is legal.
//  - Reset: async assert forces IDLE and all outputs 0, including instr_ready.
//    An instruction in flight is discarded and no rf_we occurs.
//    instr_ready=1 on the first clock edge after rst_n deassertion.
//  - instr_valid held high while busy: ignored. The next handshake is accepted only in IDLE.
// STRUCTURE
//  - Shared package (alu_pkg): opcode localparams, ALU_ADD/AND/OR/XOR op codes, FSM state encoding,
//    DATA_W/REG_AW/IMM_W defaults.
//  - One sub-module: instr_decoder (combinational).
//    Produces dst, src1, src2, imm_ext, alu_op, is_imm and illegal from instr.
//  - Top contains the FSM, instruction/field latch and result_q register.
// TESTING
//  1. r1=5, r2=7; ADD r3,r1,r2 -> rf_we,done 3 cycles after accept; rf_waddr=3, rf_wdata=12.
//  2. r1=5; ADDI r4,r1,imm=6'b111111 -> rf_wdata=4 (imm sign-extended to -1).
//  3. r1=18'h3FFFF, r2=1; ADD r5,r1,r2 -> rf_wdata=0 (wrap).
//     XOR r6,r1,r2 -> rf_wdata=18'h3FFFE.
//  4. instr op=4'b1000 -> err=1 for exactly one cycle; rf_we stays 0; instr_ready=1 two cycles after accept.
//  5. rst_n pulled low during EXEC -> rf_we/done never assert.
//     After release instr_ready=1, and a new ADD completes normally.
//  6. instr_valid held high with two queued ANDs -> accepts spaced exactly 4 cycles apart.
//     Each AND produces exactly one rf_we.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: widths, opcodes, ALU selects
// and the controller FSM encoding.
package alu_pkg;

    localparam int DATA_W = 18;
    localparam int REG_AW = 4;
    localparam int IMM_W  = 6;
    localparam int OPC_W  = 4;

    localparam logic [OPC_W-1:0] OPC_ADD  = 4'b0000;
    localparam logic [OPC_W-1:0] OPC_ADDI = 4'b0001;
    localparam logic [OPC_W-1:0] OPC_AND  = 4'b0010;
    localparam logic [OPC_W-1:0] OPC_ANDI = 4'b0011;
    localparam logic [OPC_W-1:0] OPC_OR   = 4'b0100;
    localparam logic [OPC_W-1:0] OPC_ORI  = 4'b0101;
    localparam logic [OPC_W-1:0] OPC_XOR  = 4'b0110;
    localparam logic [OPC_W-1:0] OPC_XORI = 4'b0111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_AND = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_EXEC = 3'd2,
        ST_WB   = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

endpackage

// File: rtl/alu_issue_ctrl_decoder.sv
// Purely combinational field extraction for one instruction word.
module instr_decoder
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] instr,
    output logic [REG_AW-1:0] dst,
    output logic [REG_AW-1:0] src1,
    output logic [REG_AW-1:0] src2,
    output logic [DATA_W-1:0] imm_ext,
    output logic [1:0]        alu_op,
    output logic              is_imm,
    output logic              illegal
);

    logic [OPC_W-1:0] w_opc;

    assign w_opc   = instr[DATA_W-1 -: OPC_W];
    assign dst     = instr[13:10];
    assign src1    = instr[9:6];
    assign src2    = instr[5:2];
    // Immediate is two's complement; replicate bit 5 across the upper bits.
    assign imm_ext = {{(DATA_W-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
    assign alu_op  = w_opc[2:1];
    assign is_imm  = w_opc[0];
    assign illegal = w_opc[3];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/execute controller: accepts an instruction, reads the register file,
// drives the ALU, and writes the registered result back four cycles per instruction.
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [DATA_W-1:0] instr,
    output logic [REG_AW-1:0] rf_raddr1,
    output logic [REG_AW-1:0] rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              done,
    output logic              err
);

    state_t            r_state;
    state_t            w_next;
    logic              r_ready_en;
    logic [REG_AW-1:0] r_dst;
    logic [REG_AW-1:0] r_src1;
    logic [REG_AW-1:0] r_src2;
    logic [DATA_W-1:0] r_imm_ext;
    logic [1:0]        r_alu_op;
    logic              r_is_imm;
    logic [DATA_W-1:0] r_result;

    logic [REG_AW-1:0] w_dec_dst;
    logic [REG_AW-1:0] w_dec_src1;
    logic [REG_AW-1:0] w_dec_src2;
    logic [DATA_W-1:0] w_dec_imm_ext;
    logic [1:0]        w_dec_alu_op;
    logic              w_dec_is_imm;
    logic              w_dec_illegal;
    logic              w_accept;

    instr_decoder u_decoder (
        .instr   (instr),
        .dst     (w_dec_dst),
        .src1    (w_dec_src1),
        .src2    (w_dec_src2),
        .imm_ext (w_dec_imm_ext),
        .alu_op  (w_dec_alu_op),
        .is_imm  (w_dec_is_imm),
        .illegal (w_dec_illegal)
    );

    // r_ready_en keeps instr_ready low while reset is held and rises on the first edge after release.
    assign w_accept = instr_valid && r_ready_en && (r_state == ST_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ready_en <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_ready_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dst     <= '0;
            r_src1    <= '0;
            r_src2    <= '0;
            r_imm_ext <= '0;
            r_alu_op  <= '0;
            r_is_imm  <= 1'b0;
            r_result  <= '0;
        end else begin
            if (w_accept) begin
                r_dst     <= w_dec_dst;
                r_src1    <= w_dec_src1;
                r_src2    <= w_dec_src2;
                r_imm_ext <= w_dec_imm_ext;
                r_alu_op  <= w_dec_alu_op;
                r_is_imm  <= w_dec_is_imm;
            end
            if (r_state == ST_EXEC) begin
                r_result <= alu_result;
            end
        end
    end

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        w_next      = r_state;
        instr_ready = 1'b0;
        rf_raddr1   = '0;
        rf_raddr2   = '0;
        rf_we       = 1'b0;
        rf_waddr    = '0;
        rf_wdata    = '0;
        alu_a       = '0;
        alu_b       = '0;
        alu_op      = '0;
        done        = 1'b0;
        err         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                instr_ready = r_ready_en;
                if (w_accept) begin
                    w_next = w_dec_illegal ? ST_ERR : ST_READ;
                end
            end
            ST_READ: begin
                rf_raddr1 = r_src1;
                rf_raddr2 = r_src2;
                w_next    = ST_EXEC;
            end
            ST_EXEC: begin
                alu_a  = rf_rdata1;
                alu_b  = r_is_imm ? r_imm_ext : rf_rdata2;
                alu_op = r_alu_op;
                w_next = ST_WB;
            end
            ST_WB: begin
                rf_we    = 1'b1;
                rf_waddr = r_dst;
                rf_wdata = r_result;
                done     = 1'b1;
                w_next   = ST_IDLE;
            end
            ST_ERR: begin
                err    = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios plus randomized
// instructions compared against an arithmetic model of the register file.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [17:0] instr;
    logic [3:0]  rf_raddr1;
    logic [3:0]  rf_raddr2;
    logic [17:0] rf_rdata1;
    logic [17:0] rf_rdata2;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [17:0] rf_wdata;
    logic [17:0] alu_a;
    logic [17:0] alu_b;
    logic [1:0]  alu_op;
    logic [17:0] alu_result;
    logic        done;
    logic        err;

    logic [17:0] rf   [16];
    logic [17:0] m_rf [16];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rf_raddr1   (rf_raddr1),
        .rf_raddr2   (rf_raddr2),
        .rf_rdata1   (rf_rdata1),
        .rf_rdata2   (rf_rdata2),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .done        (done),
        .err         (err)
    );

    // Environment: synchronous-read register file and combinational ALU.
    always @(posedge clk) begin
        rf_rdata1 <= rf[rf_raddr1];
        rf_rdata2 <= rf[rf_raddr2];
        if (rf_we) rf[rf_waddr] <= rf_wdata;
    end

    always_comb begin
        case (alu_op)
            2'b00:   alu_result = alu_a + alu_b;
            2'b01:   alu_result = alu_a & alu_b;
            2'b10:   alu_result = alu_a | alu_b;
            default: alu_result = alu_a ^ alu_b;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] model_imm(input logic [5:0] imm);
        int v;
        v = int'(imm);
        if (v >= 32) v = v - 64;
        return 18'(v);
    endfunction

    function automatic logic [17:0] model_b(input logic [17:0] ins);
        int opc;
        opc = int'(ins[17:14]);
        if (opc % 2 == 1) return model_imm(ins[5:0]);
        return m_rf[ins[5:2]];
    endfunction

    function automatic logic [17:0] model_result(input logic [17:0] ins);
        int opc;
        logic [17:0] a;
        logic [17:0] b;
        opc = int'(ins[17:14]);
        a   = m_rf[ins[9:6]];
        b   = model_b(ins);
        case (opc / 2)
            0:       return 18'((int'(a) + int'(b)) % 262144);
            1:       return a & b;
            2:       return a | b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic [17:0] enc_r(input int opc, input int d, input int s1, input int s2);
        return {4'(opc), 4'(d), 4'(s1), 4'(s2), 2'b00};
    endfunction

    function automatic logic [17:0] enc_i(input int opc, input int d, input int s1, input logic [5:0] imm);
        return {4'(opc), 4'(d), 4'(s1), imm};
    endfunction

    task automatic set_reg(input int idx, input logic [17:0] v);
        rf[idx]   = v;
        m_rf[idx] = v;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (instr_ready) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    // Issues one instruction and checks every cycle up to the return to idle.
    task automatic run_instr(input logic [17:0] ins, input string tag);
        bit          ok;
        logic [3:0]  opc;
        logic [17:0] exp_res;
        logic [17:0] exp_a;
        logic [17:0] exp_b;
        opc = ins[17:14];
        @(negedge clk);
        instr       = ins;
        instr_valid = 1'b1;
        wait_ready(ok);
        if (!ok) begin
            check({tag, "_accept_timeout"}, 0, 1);
            instr_valid = 1'b0;
            return;
        end
        exp_a   = m_rf[ins[9:6]];
        exp_b   = model_b(ins);
        exp_res = model_result(ins);
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = 18'($urandom);
        if (opc[3]) begin
            check({tag, "_err"}, err, 1);
            check({tag, "_err_we"}, rf_we, 0);
            check({tag, "_err_ready"}, instr_ready, 0);
            @(negedge clk);
            check({tag, "_err_clear"}, err, 0);
            check({tag, "_err_ready_back"}, instr_ready, 1);
        end else begin
            check({tag, "_raddr1"}, rf_raddr1, ins[9:6]);
            if (!opc[0]) check({tag, "_raddr2"}, rf_raddr2, ins[5:2]);
            check({tag, "_read_we"}, rf_we, 0);
            check({tag, "_busy_ready"}, instr_ready, 0);
            @(negedge clk);
            check({tag, "_alu_a"}, alu_a, exp_a);
            check({tag, "_alu_b"}, alu_b, exp_b);
            check({tag, "_alu_op"}, alu_op, opc[2:1]);
            check({tag, "_exec_we"}, rf_we, 0);
            @(negedge clk);
            check({tag, "_we"}, rf_we, 1);
            check({tag, "_done"}, done, 1);
            check({tag, "_waddr"}, rf_waddr, ins[13:10]);
            check({tag, "_wdata"}, rf_wdata, exp_res);
            m_rf[ins[13:10]] = exp_res;
            @(negedge clk);
            check({tag, "_we_clear"}, rf_we, 0);
            check({tag, "_ready_back"}, instr_ready, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] ins_a;
        logic [17:0] ins_b;
        logic [17:0] exp_a;
        logic [17:0] exp_b;
        int acc[$];
        int we_cnt;
        bit accepted_now;

        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        for (int i = 0; i < 16; i++) set_reg(i, 18'($urandom));

        #1;
        check("rst_ready", instr_ready, 0);
        check("rst_we", rf_we, 0);
        check("rst_err", err, 0);
        check("rst_done", done, 0);
        #30;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_ready_before_edge", instr_ready, 0);
        @(negedge clk);
        check("rel_ready_after_edge", instr_ready, 1);

        // Basic add
        set_reg(1, 18'd5);
        set_reg(2, 18'd7);
        run_instr(enc_r(0, 3, 1, 2), "t1_add");
        @(negedge clk);
        check("t1_rf3", rf[3], 18'd12);

        // Immediate of all ones is -1
        run_instr(enc_i(1, 4, 1, 6'b111111), "t2_addi");
        @(negedge clk);
        check("t2_rf4", rf[4], 18'd4);

        // Wrap-around and xor
        set_reg(1, 18'h3FFFF);
        set_reg(2, 18'd1);
        run_instr(enc_r(0, 5, 1, 2), "t3_add_wrap");
        run_instr(enc_r(6, 6, 1, 2), "t3_xor");
        @(negedge clk);
        check("t3_rf5", rf[5], 18'd0);
        check("t3_rf6", rf[6], 18'h3FFFE);

        // Illegal opcode
        run_instr({4'b1000, 14'h1234}, "t4_illegal");
        check("t4_rf_unchanged", rf[2], m_rf[2]);

        // Reset in the middle of execution
        set_reg(1, 18'd100);
        set_reg(2, 18'd23);
        set_reg(7, 18'h155);
        @(negedge clk);
        instr       = enc_r(0, 7, 1, 2);
        instr_valid = 1'b1;
        begin
            bit ok;
            wait_ready(ok);
            if (!ok) check("t5_accept_timeout", 0, 1);
        end
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        check("t5_in_exec", alu_a, 18'd100);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_ready", instr_ready, 0);
        check("t5_rst_alu_a", alu_a, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_rst_we", rf_we, 0);
            check("t5_rst_done", done, 0);
        end
        rst_n = 1'b1;
        #1;
        check("t5_rel_ready_before_edge", instr_ready, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_rel_we", rf_we, 0);
        end
        check("t5_ready", instr_ready, 1);
        check("t5_rf7_kept", rf[7], 18'h155);
        run_instr(enc_r(0, 7, 1, 2), "t5_add_after");
        @(negedge clk);
        check("t5_rf7", rf[7], 18'd123);

        // Two ANDs with instr_valid held high
        set_reg(1, 18'h0F0F3);
        set_reg(2, 18'h3C3C1);
        set_reg(3, 18'h2AAAA);
        ins_a = enc_r(2, 8, 1, 2);
        ins_b = enc_r(2, 9, 2, 3);
        exp_a = 18'h0C0C1;
        exp_b = 18'h28280;
        we_cnt = 0;
        @(negedge clk);
        instr       = ins_a;
        instr_valid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (rf_we) begin
                we_cnt++;
                check("t6_waddr", rf_waddr, (we_cnt == 1) ? 4'd8 : 4'd9);
                check("t6_wdata", rf_wdata, (we_cnt == 1) ? exp_a : exp_b);
            end
            accepted_now = instr_valid && instr_ready;
            if (accepted_now) acc.push_back(c);
            @(negedge clk);
            if (accepted_now) begin
                if (acc.size() == 1) instr = ins_b;
                else instr_valid = 1'b0;
            end
        end
        instr_valid = 1'b0;
        check("t6_accepts", acc.size(), 2);
        if (acc.size() >= 2) check("t6_spacing", acc[1] - acc[0], 4);
        check("t6_we_count", we_cnt, 2);
        m_rf[8] = exp_a;
        m_rf[9] = exp_b;

        // Randomized instructions against the model
        for (int n = 0; n < 60; n++) begin
            int opc;
            opc = $urandom_range(0, 8);
            if (opc == 8) opc = 8 + $urandom_range(0, 7);
            run_instr({4'(opc), 14'($urandom)}, $sformatf("rnd%0d", n));
            for (int g = $urandom_range(0, 2); g > 0; g--) @(negedge clk);
        end
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 16; i++) check($sformatf("final_rf%0d", i), rf[i], m_rf[i]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
